// File: rtl/pixel_array_controller_pkg.sv
// Shared configuration for the pixel sensor array: sizes, phase-length defaults
// and the controller state encoding.
package pixel_array_controller_pkg;

  localparam int unsigned DEFAULT_PIXEL_BITS         = 8;
  localparam int unsigned DEFAULT_PIXEL_ARRAY_HEIGHT = 2;
  localparam int unsigned DEFAULT_ERASE_CYCLES       = 5;
  localparam int unsigned DEFAULT_EXPOSE_CYCLES      = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } controller_state_t;

  // Phase counter width: large enough for the longest phase, so no wrap inside a phase.
  function automatic int unsigned phase_cnt_width(input int unsigned erase_cycles,
                                                  input int unsigned expose_cycles,
                                                  input int unsigned pixel_bits);
    int unsigned w;
    w = $clog2(erase_cycles + 1);
    if ($clog2(expose_cycles + 1) > w) w = $clog2(expose_cycles + 1);
    if (pixel_bits + 1 > w) w = pixel_bits + 1;
    return w;
  endfunction

endpackage

// File: rtl/pixel_array_controller_if.sv
// Control and readout handshake bundle between the frame sequencer and the array/sink.
interface pixel_array_controller_if #(
  parameter int unsigned PIXEL_BITS         = 8,
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 2
);
  localparam int unsigned ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

  logic                          start;
  logic                          out_ready;
  logic                          erase;
  logic                          expose;
  logic                          analog_ramp;
  logic [PIXEL_BITS-1:0]         digital_ramp;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_row;
  logic                          data_valid;
  logic [ROW_W-1:0]              row_index;
  logic                          busy;
  logic                          frame_done;

  modport master (
    input  start, out_ready,
    output erase, expose, analog_ramp, digital_ramp, read_row,
           data_valid, row_index, busy, frame_done
  );

  modport slave (
    output start, out_ready,
    input  erase, expose, analog_ramp, digital_ramp, read_row,
           data_valid, row_index, busy, frame_done
  );

endinterface

// File: rtl/pixel_array_controller_phase_timer.sv
// Loadable down-counter shared by the ERASE, EXPOSE and CONVERT phases.
module pixel_array_controller_phase_timer #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             tc_c
);

  logic [CNT_W-1:0] count_q;

  // Reload on phase entry, otherwise count down to zero and stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign tc_c = (count_q == '0);

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer: erase, expose, ramp conversion, then row-by-row readout
// under a valid/ready handshake.
module pixel_array_controller
  import pixel_array_controller_pkg::*;
#(
  parameter int unsigned PIXEL_BITS         = DEFAULT_PIXEL_BITS,
  parameter int unsigned PIXEL_ARRAY_HEIGHT = DEFAULT_PIXEL_ARRAY_HEIGHT,
  parameter int unsigned ERASE_CYCLES       = DEFAULT_ERASE_CYCLES,
  parameter int unsigned EXPOSE_CYCLES      = DEFAULT_EXPOSE_CYCLES
) (
  input logic                      CLK,
  input logic                      RESET_N,
  pixel_array_controller_if.master bus
);

  localparam int unsigned ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int unsigned CNT_W = phase_cnt_width(ERASE_CYCLES, EXPOSE_CYCLES, PIXEL_BITS);

  // Timer load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] ERASE_LOAD   = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LOAD  = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONVERT_LOAD = CNT_W'((2 ** PIXEL_BITS) - 1);

  localparam logic [ROW_W-1:0]              LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [PIXEL_ARRAY_HEIGHT-1:0] ROW_ONE  = PIXEL_ARRAY_HEIGHT'(1);

  controller_state_t state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic                          erase_q, erase_d;
  logic                          expose_q, expose_d;
  logic                          analog_ramp_q, analog_ramp_d;
  logic [PIXEL_BITS-1:0]         digital_ramp_q, digital_ramp_d;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_row_q, read_row_d;
  logic                          data_valid_q, data_valid_d;
  logic [ROW_W-1:0]              row_index_q, row_index_d;
  logic                          busy_q, busy_d;
  logic                          frame_done_q, frame_done_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic             timer_en;
  logic             phase_done_c;
  logic             handshake_c;

  assign handshake_c = data_valid_q && bus.out_ready;
  assign timer_en    = (state_q == ST_ERASE) || (state_q == ST_EXPOSE) || (state_q == ST_CONVERT);

  pixel_array_controller_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .load       (timer_load),
    .load_value (timer_load_value),
    .en         (timer_en),
    .tc_c       (phase_done_c)
  );

  // State, row pointer and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_IDLE;
      row_q          <= '0;
      erase_q        <= 1'b0;
      expose_q       <= 1'b0;
      analog_ramp_q  <= 1'b0;
      digital_ramp_q <= '0;
      read_row_q     <= '0;
      data_valid_q   <= 1'b0;
      row_index_q    <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      erase_q        <= erase_d;
      expose_q       <= expose_d;
      analog_ramp_q  <= analog_ramp_d;
      digital_ramp_q <= digital_ramp_d;
      read_row_q     <= read_row_d;
      data_valid_q   <= data_valid_d;
      row_index_q    <= row_index_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next state and next output values; outputs reflect the state being entered.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    erase_d        = 1'b0;
    expose_d       = 1'b0;
    analog_ramp_d  = 1'b0;
    digital_ramp_d = digital_ramp_q;
    read_row_d     = '0;
    data_valid_d   = 1'b0;
    row_index_d    = '0;
    busy_d         = 1'b1;
    frame_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d         = 1'b0;
        digital_ramp_d = '0;
        if (bus.start) begin
          state_d = ST_ERASE;
          erase_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_ERASE: begin
        if (phase_done_c) begin
          state_d  = ST_EXPOSE;
          expose_d = 1'b1;
        end else begin
          erase_d = 1'b1;
        end
      end

      ST_EXPOSE: begin
        if (phase_done_c) begin
          state_d        = ST_CONVERT;
          analog_ramp_d  = 1'b1;
          digital_ramp_d = '0;
        end else begin
          expose_d = 1'b1;
        end
      end

      // Ramp holds its final code through READ so pixel words stay stable.
      ST_CONVERT: begin
        if (phase_done_c) begin
          state_d      = ST_READ;
          row_d        = '0;
          read_row_d   = ROW_ONE;
          data_valid_d = 1'b1;
        end else begin
          analog_ramp_d  = 1'b1;
          digital_ramp_d = digital_ramp_q + PIXEL_BITS'(1);
        end
      end

      ST_READ: begin
        data_valid_d = 1'b1;
        if (handshake_c) begin
          if (row_q == LAST_ROW) begin
            state_d        = ST_IDLE;
            row_d          = '0;
            data_valid_d   = 1'b0;
            busy_d         = 1'b0;
            digital_ramp_d = '0;
            frame_done_d   = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
        if (data_valid_d) begin
          read_row_d  = ROW_ONE << row_d;
          row_index_d = row_d;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Phase counter is reloaded on every state entry.
    timer_load = (state_d != state_q);
    case (state_d)
      ST_ERASE:   timer_load_value = ERASE_LOAD;
      ST_EXPOSE:  timer_load_value = EXPOSE_LOAD;
      ST_CONVERT: timer_load_value = CONVERT_LOAD;
      default:    timer_load_value = '0;
    endcase
  end

  assign bus.erase        = erase_q;
  assign bus.expose       = expose_q;
  assign bus.analog_ramp  = analog_ramp_q;
  assign bus.digital_ramp = digital_ramp_q;
  assign bus.read_row     = read_row_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.row_index    = row_index_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_pixel_array_controller.sv
// Bench for pixel_array_controller with a 2x2 behavioural pixel array and a
// row scoreboard.
module tb_pixel_array_controller;

  localparam int unsigned PB    = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned EC    = 5;
  localparam int unsigned XC    = 10;
  localparam int unsigned RAMPS = 2 ** PB;
  localparam int unsigned ROW_W = 1;

  typedef struct packed {
    logic [ROW_W-1:0] idx;
    logic [H*PB-1:0]  word;
  } sb_item_t;

  logic clk;
  logic rst_n;

  pixel_array_controller_if #(.PIXEL_BITS(PB), .PIXEL_ARRAY_HEIGHT(H)) bus ();

  pixel_array_controller #(
    .PIXEL_BITS         (PB),
    .PIXEL_ARRAY_HEIGHT (H),
    .ERASE_CYCLES       (EC),
    .EXPOSE_CYCLES      (XC)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  sb_item_t sb_q[$];

  logic [PB-1:0]   trip     [H][H];
  logic [PB-1:0]   pix_code [H][H];
  logic            pix_hit  [H][H];
  logic [H*PB-1:0] row_word;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Pixel model: erased by ERASE, latches the ramp code where it first reaches the trip code.
  always @(posedge clk) begin
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < H; c++) begin
        if (bus.erase) begin
          pix_code[r][c] <= '0;
          pix_hit[r][c]  <= 1'b0;
        end else if (bus.analog_ramp && !pix_hit[r][c] && (bus.digital_ramp >= trip[r][c])) begin
          pix_code[r][c] <= bus.digital_ramp;
          pix_hit[r][c]  <= 1'b1;
        end
      end
    end
  end

  // Data bus seen by the sink: the row selected by READ_ROW.
  always_comb begin
    row_word = '0;
    for (int r = 0; r < H; r++) begin
      if (bus.read_row[r]) begin
        for (int c = 0; c < H; c++) row_word[c*PB +: PB] = pix_code[r][c];
      end
    end
  end

  // Handshake monitor: every accepted row is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.data_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_row", 32'(bus.row_index), 32'hFFFF_FFFF);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check("row_index", 32'(bus.row_index), 32'(it.idx));
        check("pixel_word", 32'(row_word), 32'(it.word));
      end
    end
  end

  function automatic logic [12:0] mk(input bit e, input bit x, input bit a, input logic [PB-1:0] ramp,
                                     input logic [H-1:0] rr, input bit dv, input logic [ROW_W-1:0] idx,
                                     input bit busy, input bit fd);
    return {e, x, a, ramp, rr, dv, idx, busy, fd};
  endfunction

  function automatic logic [12:0] outs();
    return {bus.erase, bus.expose, bus.analog_ramp, bus.digital_ramp, bus.read_row,
            bus.data_valid, bus.row_index, bus.busy, bus.frame_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int r = 0; r < H; r++) begin
      sb_item_t it;
      it.idx = ROW_W'(r);
      for (int c = 0; c < H; c++) it.word[c*PB +: PB] = trip[r][c];
      sb_q.push_back(it);
    end
  endtask

  // Start (unless already started) and walk ERASE, EXPOSE, CONVERT cycle by cycle.
  task automatic phases(input bit started, input bit poke);
    push_frame();
    if (!started) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    for (int i = 0; i < EC; i++) begin
      check("erase_phase", 32'(outs()), 32'(mk(1, 0, 0, '0, '0, 0, '0, 1, 0)));
      step();
    end
    for (int i = 0; i < XC; i++) begin
      check("expose_phase", 32'(outs()), 32'(mk(0, 1, 0, '0, '0, 0, '0, 1, 0)));
      if (poke && i == 3) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    for (int i = 0; i < RAMPS; i++) begin
      check("convert_ramp", 32'(outs()), 32'(mk(0, 0, 1, PB'(i), '0, 0, '0, 1, 0)));
      step();
    end
  endtask

  // Read out all rows after an optional stall, then check FRAME_DONE.
  task automatic read_rows(input int stall, input bit chain);
    logic [H-1:0] one;
    one = H'(1);
    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check("row0_held", 32'(outs()), 32'(mk(0, 0, 0, PB'(RAMPS - 1), H'(1), 1, '0, 1, 0)));
      step();
    end
    bus.out_ready = 1'b1;
    for (int r = 0; r < H; r++) begin
      check("read_row", 32'(outs()), 32'(mk(0, 0, 0, PB'(RAMPS - 1), one << r, 1, ROW_W'(r), 1, 0)));
      step();
    end
    bus.out_ready = 1'b0;
    check("frame_done", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 1)));
    if (chain) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (!chain) check("idle_after_frame", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trip[0][0] = PB'(3);
    trip[0][1] = PB'(7);
    trip[1][0] = PB'(12);
    trip[1][1] = PB'(15);
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset holds everything low even with START toggling.
    for (int i = 0; i < 4; i++) begin
      bus.start = ~bus.start;
      step();
      check("reset_outputs", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    step();
    check("idle_outputs", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));

    // Nominal frame, OUT_READY high.
    phases(0, 0);
    read_rows(0, 0);

    // Backpressure on row 0 for 7 cycles.
    phases(0, 0);
    read_rows(7, 0);

    // START during EXPOSE is ignored and no second frame follows.
    phases(0, 1);
    read_rows(0, 0);
    for (int i = 0; i < 4; i++) begin
      check("no_second_frame", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));
      step();
    end

    // Back-to-back frames: START in the FRAME_DONE cycle.
    phases(0, 0);
    read_rows(0, 1);
    phases(1, 0);
    read_rows(0, 0);

    // Reset while row 1 is selected: async clear, no FRAME_DONE.
    phases(0, 0);
    bus.out_ready = 1'b1;
    check("pre_reset_row0", 32'(outs()), 32'(mk(0, 0, 0, PB'(RAMPS - 1), H'(1), 1, '0, 1, 0)));
    step();
    bus.out_ready = 1'b0;
    check("pre_reset_row1", 32'(outs()), 32'(mk(0, 0, 0, PB'(RAMPS - 1), H'(2), 1, ROW_W'(1), 1, 0)));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));
    step();
    for (int i = 0; i < 3; i++) begin
      check("reset_no_done", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));
      step();
    end
    sb_q.delete();
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'(outs()), 32'(mk(0, 0, 0, '0, '0, 0, '0, 0, 0)));
    phases(0, 0);
    read_rows(0, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
